// File: rtl/soc_bus_pkg.sv
// soc_bus_dec shared types: FSM encoding, error data default
// and select-field helpers.
package soc_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [31:0] ERR_DATA_DEF = 32'hDEAD_BEEF;
  localparam int          SEL_W_DEF    = 2;

  function automatic int sel_lsb(int aw, int sw);
    return aw - sw;
  endfunction

endpackage

// File: rtl/soc_bus_dec_if.sv
// Master request/response channel plus the shared slave channel.
// master: bus master and slaves side; slave: the decoder itself.
interface soc_bus_dec_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int NSLAVE = 4
);
  logic [ADDR_W-1:0]        m_addr;
  logic                     m_rw;
  logic [DATA_W-1:0]        m_dwrite;
  logic                     m_valid;
  logic [DATA_W-1:0]        m_dread;
  logic                     m_ready;
  logic                     m_err;
  logic [ADDR_W-1:0]        fault_addr;
  logic [ADDR_W-1:0]        s_addr;
  logic                     s_rw;
  logic [DATA_W-1:0]        s_dwrite;
  logic [NSLAVE-1:0]        s_valid;
  logic [NSLAVE-1:0]        s_ready;
  logic [NSLAVE*DATA_W-1:0] s_dread;

  modport master (
    output m_addr, m_rw, m_dwrite, m_valid,
    output s_ready, s_dread,
    input  m_dread, m_ready, m_err, fault_addr,
    input  s_addr, s_rw, s_dwrite, s_valid
  );

  modport slave (
    input  m_addr, m_rw, m_dwrite, m_valid,
    input  s_ready, s_dread,
    output m_dread, m_ready, m_err, fault_addr,
    output s_addr, s_rw, s_dwrite, s_valid
  );
endinterface

// File: rtl/soc_bus_timer.sv
// Loadable up-counter with terminal flag for the slave timeout.
// Only present when SOC_BUS_TIMEOUT_EN is defined.
`ifdef SOC_BUS_TIMEOUT_EN
module soc_bus_timer #(
  parameter int LIMIT = 255,
  localparam int CW = (LIMIT > 1) ? $clog2(LIMIT) : 1
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic en,
  output logic done
);
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || load) cnt <= '0;
    else if (en)       cnt <= cnt + 1'b1;
  end

  // flags the cycle whose edge would bring the count to LIMIT
  assign done = en && (cnt == CW'(LIMIT - 1));
endmodule
`endif

// File: rtl/soc_bus_dec.sv
// Single-outstanding address decoder: master to NSLAVE one-hot slaves.
// Optional slave timeout via SOC_BUS_TIMEOUT_EN.
module soc_bus_dec
  import soc_bus_pkg::*;
#(
  parameter int          ADDR_W   = 32,
  parameter int          DATA_W   = 32,
  parameter int          NSLAVE   = 4,
  parameter int          SEL_W    = SEL_W_DEF,
  parameter int          TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = ERR_DATA_DEF
) (
  input logic          clk,
  input logic          reset,
  soc_bus_dec_if.slave bus
);
  state_t            state, state_n;
  logic [SEL_W-1:0]  idx, sel;
  logic [ADDR_W-1:0] s_addr, fault_addr;
  logic [DATA_W-1:0] s_dwrite, dread, rsel;
  logic              s_rw, err, hit, rdy, tmo;
  logic              ld, cap, fail;

  assign sel = bus.m_addr[sel_lsb(ADDR_W, SEL_W) +: SEL_W];
  assign hit = int'(sel) < NSLAVE;

  always_comb begin
    rdy  = 1'b0;
    rsel = '0;
    for (int i = 0; i < NSLAVE; i++) begin
      if (int'(idx) == i) begin
        rdy  = bus.s_ready[i];
        rsel = bus.s_dread[i*DATA_W +: DATA_W];
      end
    end
  end

`ifdef SOC_BUS_TIMEOUT_EN
  soc_bus_timer #(.LIMIT(TIMEOUT)) u_timer (
    .clk   (clk),
    .reset (reset),
    .load  (ld),
    .en    (state == ST_REQ && !rdy),
    .done  (tmo)
  );
`else
  assign tmo = 1'b0;
`endif

  always_comb begin
    state_n = state;
    ld      = 1'b0;
    cap     = 1'b0;
    fail    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (bus.m_valid) begin
          ld = 1'b1;
          if (hit) begin
            state_n = ST_REQ;
          end else begin
            fail    = 1'b1;
            state_n = ST_RESP;
          end
        end
      end
      ST_REQ: begin
        // ready beats a timeout landing on the same edge
        if (rdy) begin
          cap     = 1'b1;
          state_n = ST_RESP;
        end else if (tmo) begin
          fail    = 1'b1;
          state_n = ST_RESP;
        end
      end
      ST_RESP: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      idx        <= '0;
      s_addr     <= '0;
      s_rw       <= 1'b0;
      s_dwrite   <= '0;
      dread      <= '0;
      err        <= 1'b0;
      fault_addr <= '0;
    end else begin
      state <= state_n;
      if (ld) begin
        idx      <= sel;
        s_addr   <= bus.m_addr;
        s_rw     <= bus.m_rw;
        s_dwrite <= bus.m_dwrite;
      end
      if (cap) begin
        dread <= rsel;
        err   <= 1'b0;
      end
      if (fail) begin
        dread      <= DATA_W'(ERR_DATA);
        err        <= 1'b1;
        fault_addr <= ld ? bus.m_addr : s_addr;
      end
    end
  end

  always_comb begin
    bus.s_valid = '0;
    for (int i = 0; i < NSLAVE; i++)
      bus.s_valid[i] = (state == ST_REQ) && (int'(idx) == i);
  end

  assign bus.m_ready    = (state == ST_RESP);
  assign bus.m_err      = (state == ST_RESP) && err;
  assign bus.m_dread    = dread;
  assign bus.fault_addr = fault_addr;
  assign bus.s_addr     = s_addr;
  assign bus.s_rw       = s_rw;
  assign bus.s_dwrite   = s_dwrite;
endmodule

// File: tb/tb_soc_bus_dec.sv
// Directed bench for soc_bus_dec: a 4-slave and a 3-slave instance.
// Timeout cases apply when SOC_BUS_TIMEOUT_EN is defined.
module tb_soc_bus_dec;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  soc_bus_dec_if #(.NSLAVE(4)) bus  ();
  soc_bus_dec_if #(.NSLAVE(3)) bus3 ();

  soc_bus_dec #(.NSLAVE(4), .TIMEOUT(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  soc_bus_dec #(.NSLAVE(3), .TIMEOUT(8)) dut3 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus3.slave)
  );

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [31:0] a, input logic rw,
                     input logic [31:0] d);
    bus.m_addr   = a;
    bus.m_rw     = rw;
    bus.m_dwrite = d;
    bus.m_valid  = 1'b1;
  endtask

  int   n;
  logic seen;

  initial begin
    reset = 1'b1;
    bus.m_addr = '0;  bus.m_rw = 1'b0;  bus.m_dwrite = '0;
    bus.m_valid = 1'b0;  bus.s_ready = '0;  bus.s_dread = '0;
    bus3.m_addr = '0; bus3.m_rw = 1'b0; bus3.m_dwrite = '0;
    bus3.m_valid = 1'b0; bus3.s_ready = '0; bus3.s_dread = '0;
    cyc();
    cyc();
    check("rst_svalid", bus.s_valid, 4'b0000);
    check("rst_mready", bus.m_ready, 1'b0);
    check("rst_merr", bus.m_err, 1'b0);
    check("rst_dread", bus.m_dread, 32'h0);
    check("rst_saddr", bus.s_addr, 32'h0);
    check("rst_fault", bus.fault_addr, 32'h0);
    check("rst3_mready", bus3.m_ready, 1'b0);
    reset = 1'b0;
    cyc();

    // read slave1, ready in cycle 3
    req(32'h4000_0010, 1'b0, 32'h0);
    cyc();
    check("rd1_sv_c1", bus.s_valid, 4'b0010);
    check("rd1_saddr", bus.s_addr, 32'h4000_0010);
    check("rd1_srw", bus.s_rw, 1'b0);
    cyc();
    check("rd1_sv_c2", bus.s_valid, 4'b0010);
    check("rd1_mr_c2", bus.m_ready, 1'b0);
    cyc();
    check("rd1_sv_c3", bus.s_valid, 4'b0010);
    bus.s_ready = 4'b0011;
    bus.s_dread[0*32 +: 32] = 32'h0BAD_0BAD;
    bus.s_dread[1*32 +: 32] = 32'h1234_5678;
    cyc();
    check("rd1_mr_c4", bus.m_ready, 1'b1);
    check("rd1_err", bus.m_err, 1'b0);
    check("rd1_dread", bus.m_dread, 32'h1234_5678);
    check("rd1_sv_c4", bus.s_valid, 4'b0000);
    bus.m_valid = 1'b0;
    bus.s_ready = '0;
    cyc();
    check("rd1_mr_c5", bus.m_ready, 1'b0);

    // unmapped index 3 on the 3-slave decoder
    bus3.m_addr  = 32'hC000_0000;
    bus3.m_valid = 1'b1;
    bus3.s_ready = 3'b111;
    cyc();
    check("um_sv", bus3.s_valid, 3'b000);
    check("um_mr", bus3.m_ready, 1'b1);
    check("um_err", bus3.m_err, 1'b1);
    check("um_dread", bus3.m_dread, 32'hDEAD_BEEF);
    check("um_fault", bus3.fault_addr, 32'hC000_0000);
    bus3.m_valid = 1'b0;
    bus3.s_ready = '0;
    cyc();
    check("um_mr_c2", bus3.m_ready, 1'b0);
    check("um_err_c2", bus3.m_err, 1'b0);
    check("um_fault_hold", bus3.fault_addr, 32'hC000_0000);

    // reset two cycles into REQ, late ready
    req(32'h8000_0004, 1'b1, 32'h7777_0000);
    cyc();
    cyc();
    check("ra_sv_c2", bus.s_valid, 4'b0100);
    reset = 1'b1;
    bus.m_valid = 1'b0;
    cyc();
    reset = 1'b0;
    check("ra_sv_c3", bus.s_valid, 4'b0000);
    check("ra_saddr", bus.s_addr, 32'h0);
    check("ra_swdata", bus.s_dwrite, 32'h0);
    check("ra_srw", bus.s_rw, 1'b0);
    check("ra_dread", bus.m_dread, 32'h0);
    bus.s_ready = 4'b0100;
    bus.s_dread[2*32 +: 32] = 32'h5555_AAAA;
    cyc();
    check("ra_mr_c4", bus.m_ready, 1'b0);
    check("ra_sv_c4", bus.s_valid, 4'b0000);
    check("ra_dread_c4", bus.m_dread, 32'h0);
    bus.s_ready = '0;
    cyc();

    // back-to-back: write slave0 then read slave3
    req(32'h0000_0100, 1'b1, 32'hA5A5_0001);
    cyc();
    check("bb_sv0", bus.s_valid, 4'b0001);
    check("bb_srw0", bus.s_rw, 1'b1);
    check("bb_swd0", bus.s_dwrite, 32'hA5A5_0001);
    bus.s_ready = 4'b0001;
    cyc();
    check("bb_mr0", bus.m_ready, 1'b1);
    check("bb_err0", bus.m_err, 1'b0);
    bus.s_ready = '0;
    cyc();
    check("bb_mr_idle", bus.m_ready, 1'b0);
    req(32'hC000_0020, 1'b0, 32'h0000_0000);
    cyc();
    check("bb_sv3", bus.s_valid, 4'b1000);
    check("bb_srw3", bus.s_rw, 1'b0);
    check("bb_saddr3", bus.s_addr, 32'hC000_0020);
    bus.s_ready = 4'b1000;
    bus.s_dread[3*32 +: 32] = 32'hCAFE_F00D;
    cyc();
    check("bb_mr3", bus.m_ready, 1'b1);
    check("bb_dread3", bus.m_dread, 32'hCAFE_F00D);
    bus.m_valid = 1'b0;
    bus.s_ready = '0;
    cyc();
    check("bb_mr3_c2", bus.m_ready, 1'b0);

    // slave2 silent
    req(32'h8000_0000, 1'b0, 32'h0);
    cyc();
    n    = 0;
    seen = 1'b0;
`ifdef SOC_BUS_TIMEOUT_EN
    for (int i = 0; i < 30; i++) begin
      if (bus.m_ready) begin
        seen = 1'b1;
        break;
      end
      if (bus.s_valid == 4'b0100) n++;
      cyc();
    end
    check("tmo_seen", seen, 1'b1);
    check("tmo_len", n, 8);
    check("tmo_err", bus.m_err, 1'b1);
    check("tmo_dread", bus.m_dread, 32'hDEAD_BEEF);
    check("tmo_fault", bus.fault_addr, 32'h8000_0000);
    bus.m_valid = 1'b0;
    cyc();
    req(32'h8000_0008, 1'b0, 32'h0);
    cyc();
    for (int i = 0; i < 7; i++) cyc();
    check("tmo8_sv", bus.s_valid, 4'b0100);
    bus.s_ready = 4'b0100;
    bus.s_dread[2*32 +: 32] = 32'h55AA_55AA;
    cyc();
    check("tmo8_mr", bus.m_ready, 1'b1);
    check("tmo8_err", bus.m_err, 1'b0);
    check("tmo8_dread", bus.m_dread, 32'h55AA_55AA);
    check("tmo8_fault", bus.fault_addr, 32'h8000_0000);
`else
    for (int i = 0; i < 20; i++) begin
      if (bus.m_ready) seen = 1'b1;
      if (bus.s_valid == 4'b0100) n++;
      cyc();
    end
    check("wait_seen", seen, 1'b0);
    check("wait_len", n, 20);
    bus.s_ready = 4'b0100;
    bus.s_dread[2*32 +: 32] = 32'h55AA_55AA;
    cyc();
    check("wait_mr", bus.m_ready, 1'b1);
    check("wait_err", bus.m_err, 1'b0);
    check("wait_dread", bus.m_dread, 32'h55AA_55AA);
    check("wait_fault", bus.fault_addr, 32'h0);
`endif
    bus.m_valid = 1'b0;
    bus.s_ready = '0;
    cyc();
    check("end_mr", bus.m_ready, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
